calc_result_bcd_v: RTL and testbench



---
 rtl/calc_result_bcd_v_pkg.sv | 20 ++
 rtl/bcd_digit_adj_v.sv | 9 +
 rtl/calc_result_bcd_v.sv | 81 ++++++++
 tb/tb_calc_result_bcd_v.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/calc_result_bcd_v_pkg.sv
// rtl/calc_result_bcd_v_pkg.sv - shared state encoding and sizing for the binary-to-BCD converter
package calc_result_bcd_v_pkg;

  localparam int IN_W_DEF   = 9;
  localparam int DIGITS_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter only needs to reach IN_W-1, so clog2(IN_W) bits suffice.
  function automatic int cnt_width(input int in_w);
    return (in_w > 1) ? $clog2(in_w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(IN_W_DEF);

endpackage

// File: rtl/bcd_digit_adj_v.sv
// rtl/bcd_digit_adj_v.sv - per-digit add-3 correction for shift-and-add-3 conversion
module bcd_digit_adj_v (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/calc_result_bcd_v.sv
// rtl/calc_result_bcd_v.sv - serial binary-to-packed-BCD converter for the calculator result
module calc_result_bcd_v
  import calc_result_bcd_v_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [IN_W-1:0]       i_bin,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CNT_W = cnt_width(IN_W);
  localparam int BCD_W = 4*DIGITS;

  state_t             state, state_nxt;
  logic [IN_W-1:0]    bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [CNT_W-1:0]   cnt;
  logic               last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj_v u_adj (
      .digit (bcd_reg[4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
  end

  // The binary MSB falls into the BCD LSB; the top adjusted bit is dropped (range guarantees it is 0).
  assign bcd_shift  = {bcd_adj[BCD_W-2:0], bin_reg[IN_W-1]};
  assign last_shift = (cnt == CNT_W'(IN_W-1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      bin_reg <= '0;
      bcd_reg <= '0;
      cnt     <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
    end else begin
      state   <= state_nxt;
      o_busy  <= (state_nxt != ST_IDLE);
      o_valid <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            bin_reg <= i_bin;
            bcd_reg <= '0;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_reg <= bcd_shift;
          bin_reg <= {bin_reg[IN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (last_shift) o_bcd <= bcd_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_bcd_v.sv
// tb/tb_calc_result_bcd_v.sv - scoreboard bench for calc_result_bcd_v
module tb_calc_result_bcd_v;

  localparam int IN_W   = 9;
  localparam int DIGITS = 3;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [8:0]  i_bin   = '0;
  logic        o_busy;
  logic        o_valid;
  logic [11:0] o_bcd;

  typedef struct {
    logic [11:0] bcd;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          busy_run = 0;
  logic [11:0] last_bcd = '0;

  calc_result_bcd_v #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_bcd   (o_bcd)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: pops expected results whenever the DUT reports a finished conversion.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst_n) begin
      busy_run = 0;
    end else begin
      if (o_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got o_valid=1 o_bcd=%0h expected no result (t=%0t)", o_bcd, $time);
        end else begin
          e = q.pop_front();
          check("bcd", int'(o_bcd), int'(e.bcd));
          check("latency", cyc - e.acc, IN_W);
          check("busy_with_valid", int'(o_busy), 1);
          last_bcd = e.bcd;
        end
      end
      if (o_busy) busy_run++;
      else if (busy_run != 0) begin
        check("busy_len", busy_run, IN_W + 1);
        busy_run = 0;
      end
    end
  end

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  // Called at posedge+1 with the DUT idle; issues a start and pushes the expectation.
  task automatic issue(input int v);
    exp_t e;
    i_start = 1'b1;
    i_bin   = 9'(v);
    e.bcd   = to_bcd(v);
    e.acc   = cyc + 1;
    q.push_back(e);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_bin   = 9'($urandom);
  endtask

  task automatic run_conv(input int v);
    issue(v);
    wait_done();
  endtask

  int directed[9] = '{0, 150, 195, 25, 467, 511, 9, 99, 100};

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_bcd", int'(o_bcd), 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    foreach (directed[i]) run_conv(directed[i]);

    repeat (5) @(posedge i_clk);
    #1;
    check("hold_idle", int'(o_bcd), int'(last_bcd));

    // start requests and input changes during a conversion must be ignored
    issue(150);
    repeat (3) @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_bin   = 9'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_bin   = 9'($urandom);
    wait_done();
    repeat (15) @(posedge i_clk);
    #1;
    check("no_second_conv", int'(o_bcd), int'(to_bcd(150)));

    // asynchronous reset in the middle of a conversion discards it
    issue(195);
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_busy", int'(o_busy), 0);
    check("arst_valid", int'(o_valid), 0);
    check("arst_bcd", int'(o_bcd), 0);
    last_bcd = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (12) @(posedge i_clk);
    #1;
    check("arst_hold_bcd", int'(o_bcd), 0);
    run_conv(25);

    for (int n = 0; n < 30; n++) run_conv(int'($urandom_range(0, 511)));

    repeat (5) @(posedge i_clk);
    #1;
    check("final_hold", int'(o_bcd), int'(last_bcd));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
